// File: rtl/fifo_wr_burst_sched.sv
// Write-side burst scheduler for the async FIFO: paces upstream words into winc/wdata.
// Optional stall counter output enabled by defining FIFO_WR_STALL_COUNT_EN.
module fifo_wr_burst_sched #(
  parameter int unsigned DATASIZE     = 8,
  parameter int unsigned ADDRSIZE     = 10,
  parameter int unsigned WRITE_PERIOD = 2,
  parameter int unsigned BURST_LENGTH = 1024,
  parameter int unsigned CNTW         = 11
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNTW-1:0]     cfg_len,
  input  logic [3:0]          cfg_period,
  input  logic                s_valid,
  input  logic [DATASIZE-1:0] s_data,
  output logic                s_ready,
  input  logic                wfull,
  output logic                winc,
  output logic [DATASIZE-1:0] wdata,
  output logic                busy,
  output logic                done,
  output logic [CNTW-1:0]     words_written
`ifdef FIFO_WR_STALL_COUNT_EN
  ,
  output logic [15:0]         stall_cycles
`endif
);

  localparam logic [CNTW-1:0] DefLen    = CNTW'(BURST_LENGTH);
  localparam logic [3:0]      DefPeriod = 4'(WRITE_PERIOD);

  // Reject parameter sets that would let the word counter wrap or the gap overflow.
  if (ADDRSIZE == 0 || WRITE_PERIOD < 1 || WRITE_PERIOD > 15 ||
      (64'd1 << CNTW) <= 64'(BURST_LENGTH)) begin : g_bad_cfg
    $error("fifo_wr_burst_sched: illegal parameter combination");
  end

  typedef enum logic [0:0] {StIdle, StArmed} state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] len_q, len_d;
  logic [3:0]      period_q, period_d;
  logic [3:0]      gap_q, gap_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    period_d = period_q;
    gap_d    = gap_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    s_ready  = 1'b0;
    winc     = 1'b0;
    wdata    = s_data;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          len_d    = (cfg_len == '0) ? DefLen : cfg_len;
          period_d = (cfg_period == '0) ? DefPeriod : cfg_period;
          cnt_d    = '0;
          gap_d    = '0;
          state_d  = StArmed;
        end
      end
      StArmed: begin
        s_ready = (gap_q == '0) && !wfull && !abort;
        winc    = s_valid && s_ready;
        if (winc) begin
          cnt_d = cnt_q + 1'b1;
          gap_d = period_q - 4'd1;
          if (cnt_d == len_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else if (gap_q != '0) begin
          // Slot timer keeps running while data or FIFO space is missing.
          gap_d = gap_q - 4'd1;
        end
        if (abort) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      period_q <= '0;
      gap_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      period_q <= period_d;
      gap_q    <= gap_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign busy          = (state_q == StArmed);
  assign done          = done_q;
  assign words_written = cnt_q;

`ifdef FIFO_WR_STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == StIdle) begin
      if (start && !abort) stall_d = '0;
    end else if (gap_q == '0 && s_valid && wfull && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_burst_sched.sv
// Self-checking bench for fifo_wr_burst_sched: vector table plus directed multi-cycle sequences.
module tb_fifo_wr_burst_sched;

  localparam int unsigned CNTW = 11;

  logic            wclk = 1'b0;
  logic            wrst, start, abort, s_valid, wfull;
  logic [CNTW-1:0] cfg_len;
  logic [3:0]      cfg_period;
  logic [7:0]      s_data;
  logic            s_ready, winc, busy, done;
  logic [7:0]      wdata;
  logic [CNTW-1:0] words_written;
`ifdef FIFO_WR_STALL_COUNT_EN
  logic [15:0]     stall_cycles;
`endif

  fifo_wr_burst_sched dut (
    .wclk          (wclk),
    .wrst          (wrst),
    .start         (start),
    .abort         (abort),
    .cfg_len       (cfg_len),
    .cfg_period    (cfg_period),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .wfull         (wfull),
    .winc          (winc),
    .wdata         (wdata),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
`ifdef FIFO_WR_STALL_COUNT_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 wclk = ~wclk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic            start, abort;
    logic [CNTW-1:0] len;
    logic [3:0]      per;
    logic            sv;
    logic [7:0]      sd;
    logic            wf;
    logic            rdy, wi;
    logic [7:0]      wd;
    logic            bz, dn;
    logic [CNTW-1:0] ww;
  } vec_t;

  vec_t vecs[14];

  int nw, first, last, dcyc, w3, w4, viol, dseen;
  int wc[3];
  logic dbusy;
  logic [CNTW-1:0] dww;

  initial begin
    // start abort len per sv sd wf | rdy wi wd bz dn ww
    vecs[0]  = '{0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0};
    vecs[1]  = '{1, 0, 4, 0, 1, 8'h10, 0, 0, 0, 8'h00, 0, 0, 0};
    vecs[2]  = '{0, 0, 4, 0, 1, 8'h10, 0, 1, 1, 8'h10, 1, 0, 0};
    vecs[3]  = '{1, 0, 2, 0, 1, 8'h11, 0, 0, 0, 8'h00, 1, 0, 1};  // start while armed: ignored
    vecs[4]  = '{0, 0, 4, 0, 1, 8'h11, 0, 1, 1, 8'h11, 1, 0, 1};
    vecs[5]  = '{0, 0, 4, 0, 1, 8'h12, 0, 0, 0, 8'h00, 1, 0, 2};
    vecs[6]  = '{0, 0, 4, 0, 1, 8'h12, 0, 1, 1, 8'h12, 1, 0, 2};
    vecs[7]  = '{0, 0, 4, 0, 1, 8'h13, 0, 0, 0, 8'h00, 1, 0, 3};
    vecs[8]  = '{0, 0, 4, 0, 1, 8'h13, 0, 1, 1, 8'h13, 1, 0, 3};
    vecs[9]  = '{1, 0, 1, 1, 1, 8'h20, 0, 0, 0, 8'h00, 0, 1, 4};  // start in done cycle
    vecs[10] = '{0, 0, 1, 1, 1, 8'h20, 0, 1, 1, 8'h20, 1, 0, 0};
    vecs[11] = '{0, 0, 1, 1, 1, 8'h21, 0, 0, 0, 8'h00, 0, 1, 1};
    vecs[12] = '{1, 1, 5, 1, 1, 8'h21, 0, 0, 0, 8'h00, 0, 0, 1};  // abort beats start
    vecs[13] = '{0, 0, 5, 1, 1, 8'h21, 0, 0, 0, 8'h00, 0, 0, 1};

    wrst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; wfull = 1'b0;
    cfg_len = '0; cfg_period = '0; s_data = '0;
    repeat (2) @(negedge wclk);
    wrst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      start = vecs[i].start; abort = vecs[i].abort; cfg_len = vecs[i].len;
      cfg_period = vecs[i].per; s_valid = vecs[i].sv; s_data = vecs[i].sd; wfull = vecs[i].wf;
      #1;
      chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d_winc", i), 32'(winc), 32'(vecs[i].wi));
      if (vecs[i].wi) chk($sformatf("v%0d_wdata", i), 32'(wdata), 32'(vecs[i].wd));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bz));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].dn));
      chk($sformatf("v%0d_words", i), 32'(words_written), 32'(vecs[i].ww));
      @(negedge wclk);
    end
    start = 1'b0; abort = 1'b0;

    // Default-length burst, back-to-back writes
    start = 1'b1; cfg_len = '0; cfg_period = 4'd1; s_valid = 1'b1; wfull = 1'b0;
    @(negedge wclk);
    start = 1'b0;
    nw = 0; first = -1; last = -1; dcyc = -1; dbusy = 1'b1; dww = '0;
    for (int c = 0; c < 1100; c++) begin
      #1;
      if (winc) begin
        if (first < 0) first = c;
        last = c;
        nw++;
      end
      if (done) begin
        dcyc = c; dbusy = busy; dww = words_written;
        break;
      end
      @(negedge wclk);
    end
    chk("b1024_writes", nw, 1024);
    chk("b1024_consecutive", last - first + 1, 1024);
    chk("b1024_done_cycle", dcyc, last + 1);
    chk("b1024_words", 32'(dww), 1024);
    chk("b1024_busy_at_done", 32'(dbusy), 0);

    // wfull held for 5 cycles after the 3rd write
    @(negedge wclk);
    start = 1'b1; cfg_len = 11'd8; cfg_period = 4'd1; s_valid = 1'b1;
    @(negedge wclk);
    start = 1'b0;
    nw = 0; w3 = -1; w4 = -1; viol = 0; dcyc = -1; dww = '0;
    for (int c = 0; c < 40; c++) begin
      wfull = (w3 >= 0) && (c > w3) && (c <= w3 + 5);
      #1;
      if (wfull && (s_ready || winc)) viol++;
      if (winc) begin
        nw++;
        if (nw == 3) w3 = c;
        if (nw == 4) w4 = c;
      end
      if (done) begin
        dcyc = c; dww = words_written;
        break;
      end
      @(negedge wclk);
    end
    wfull = 1'b0;
    chk("full_blocked", viol, 0);
    chk("full_resume_cycle", w4, w3 + 6);
    chk("full_total_writes", nw, 8);
    chk("full_done_cycle", dcyc, 13);
    chk("full_words", 32'(dww), 8);
`ifdef FIFO_WR_STALL_COUNT_EN
    chk("full_stall_cycles", 32'(stall_cycles), 5);
`endif

    // Missed slot taken as soon as s_valid returns
    @(negedge wclk);
    start = 1'b1; cfg_len = 11'd3; cfg_period = 4'd3; s_valid = 1'b1;
    @(negedge wclk);
    start = 1'b0;
    nw = 0; dcyc = -1; wc[0] = -1; wc[1] = -1; wc[2] = -1;
    for (int c = 0; c < 40; c++) begin
      s_valid = !(c >= 1 && c <= 4);
      #1;
      if (winc && nw < 3) begin
        wc[nw] = c;
        nw++;
      end
      if (done) begin
        dcyc = c;
        break;
      end
      @(negedge wclk);
    end
    s_valid = 1'b1;
    chk("slot_write0", wc[0], 0);
    chk("slot_write1", wc[1], 5);
    chk("slot_write2", wc[2], 8);
    chk("slot_done_cycle", dcyc, 9);

    // Abort after the 3rd write
    @(negedge wclk);
    start = 1'b1; cfg_len = 11'd10; cfg_period = 4'd1;
    @(negedge wclk);
    start = 1'b0;
    nw = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (winc) nw++;
      @(negedge wclk);
    end
    chk("abort_prewrites", nw, 3);
    abort = 1'b1;
    #1;
    chk("abort_winc", 32'(winc), 0);
    chk("abort_s_ready", 32'(s_ready), 0);
    chk("abort_busy_same", 32'(busy), 1);
    @(negedge wclk);
    abort = 1'b0;
    dseen = 0;
    #1;
    chk("abort_busy_next", 32'(busy), 0);
    chk("abort_words", 32'(words_written), 3);
    for (int c = 0; c < 4; c++) begin
      if (done) dseen++;
      @(negedge wclk);
      #1;
    end
    chk("abort_no_done", dseen, 0);
    chk("abort_words_hold", 32'(words_written), 3);

    // Reset mid-burst with a coincident start
    @(negedge wclk);
    start = 1'b1; cfg_len = 11'd10; cfg_period = 4'd1;
    @(negedge wclk);
    start = 1'b0;
    @(negedge wclk);
    @(negedge wclk);
    wrst = 1'b1; start = 1'b1;
    @(negedge wclk);
    wrst = 1'b0; start = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_winc", 32'(winc), 0);
    chk("rst_words", 32'(words_written), 0);
`ifdef FIFO_WR_STALL_COUNT_EN
    chk("rst_stall", 32'(stall_cycles), 0);
`endif
    @(negedge wclk);
    #1;
    chk("rst_stays_idle", 32'(busy), 0);
    chk("rst_no_done", 32'(done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_burst_sched.md
Name: fifo_wr_burst_sched

Overview:
- Write-side burst scheduler for the asynchronous FIFO. Runs in the write clock domain only.
- Sequences bursts of words from an upstream valid/ready source into the FIFO write port (winc/wdata).
- Paces writes to a programmable period and never writes while wfull is high.
- Counts words and reports burst completion so benches and system control can run write bursts.

Parameters:
- DATASIZE, 8, FIFO data width.
- ADDRSIZE, 10, FIFO address width; informational, FIFO depth is 2**ADDRSIZE.
- WRITE_PERIOD, 2, default cycles between successive writes; used when cfg_period==0; must be 1..15.
- BURST_LENGTH, 1024, default burst length; used when cfg_len==0.
- CNTW, 11, word-count width; must satisfy 2**CNTW > BURST_LENGTH.

Ports:
- wclk  in  1  write clock.
- wrst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a burst.
- abort  in  1  terminate the active burst.
- cfg_len  in  CNTW  words in the burst; 0 selects BURST_LENGTH.
- cfg_period  in  4  cycles per write slot; 0 selects WRITE_PERIOD.
- s_valid  in  1  upstream data valid.
- s_data  in  DATASIZE  upstream data.
- s_ready  out  1  upstream accept.
- wfull  in  1  FIFO full flag, write domain.
- winc  out  1  FIFO write enable.
- wdata  out  DATASIZE  FIFO write data.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse on burst completion.
- words_written  out  CNTW  words written in the current or last burst.

Behaviour:
- Clocking and reset: single clock wclk; wrst is synchronous, active-high. All state updates on the rising edge of wclk.
- Reset values: state=IDLE, busy=0, done=0, s_ready=0, winc=0, words_written=0, gap counter=0, latched len/period=0.
- States: IDLE, ARMED.
- IDLE:
  - start=1 && abort=0: latch len (cfg_len, or BURST_LENGTH if 0) and period (cfg_period, or WRITE_PERIOD if 0); clear words_written and gap; go to ARMED.
  - start=1 && abort=1: abort wins; stay in IDLE.
- ARMED:
  - busy=1.
  - Eligible = (gap==0) && !wfull && !abort.
  - s_ready = eligible; combinational.
  - Transfer = s_valid && s_ready. winc = transfer; wdata = s_data; combinational, zero latency.
  - wdata is don't-care when winc=0.
- On each transfer: words_written += 1; gap loads period-1. Otherwise gap decrements, saturating at 0.
  - Effect: writes are spaced at least period cycles apart. period=1 allows back-to-back writes.
  - A write at cycle a makes a+P the earliest next write.
- Pacing is slot-based, not data-based:
  - s_valid low or wfull high does not reload gap.
  - A missed slot is taken at the first cycle conditions allow.
- wfull: s_ready forced low the same cycle. The FIFO's registered wfull already reflects all prior writes, so overflow is impossible.
- Completion:
  - The transfer that makes words_written==len returns the FSM to IDLE at the next edge.
  - done=1 for exactly that next cycle; busy=0 from that cycle.
  - start in the done cycle is accepted.
- abort in ARMED: s_ready/winc blocked that cycle; IDLE next edge; done stays 0; words_written holds the partial count.
- start while in ARMED is ignored.
- wrst mid-burst: return to reset values at the next edge; no done pulse. start coincident with wrst is ignored.
- words_written holds its value in IDLE until the next accepted start.
- Counter arithmetic is unsigned CNTW bits; it cannot wrap because len ≤ 2**CNTW-1.

Optional Feature:
- Macro: FIFO_WR_STALL_COUNT_EN.
- Defined:
  - Adds output stall_cycles, 16 bits, reset value 0, cleared on accepted start.
  - Increments each ARMED cycle with gap==0 && s_valid && wfull; saturates at 16'hFFFF; holds in IDLE.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Stimulus: wrst 2 cycles; start with cfg_len=4, cfg_period=0; s_valid=1, s_data increments from 8'h10; wfull=0.
  Response: winc on ARMED cycles 0,2,4,6; wdata 10,11,12,13; done pulse at cycle 7; words_written=4; busy=0 at cycle 7.
- Stimulus: cfg_len=0, cfg_period=1, s_valid=1, wfull=0.
  Response: 1024 consecutive winc cycles; done one cycle after the last write; words_written=1024.
- Stimulus: cfg_len=8, period 1; wfull held high for 5 cycles after the 3rd write.
  Response: s_ready=0 and winc=0 for those 5 cycles; writes resume the cycle wfull drops; 8 total writes; stall_cycles=5 when the macro is defined.
- Stimulus: cfg_period=3; s_valid deasserted for 4 cycles after a write.
  Response: the next write occurs the first cycle s_valid returns, with no extra gap penalty.
- Stimulus: abort after the 3rd write of cfg_len=10.
  Response: no winc in the abort cycle; busy=0 next cycle; done never pulses; words_written=3.
- Stimulus: wrst asserted mid-burst, with start asserted in the same cycle.
  Response: all outputs return to reset values next edge; FSM remains in IDLE.
